// File: rtl/ym3438_pg_pkg.sv
// Shared types and the OPN2 detune table for the phase generator.
// Detune rows are indexed by dt[1:0]-1; dt[1:0]=0 means no detune.
package ym3438_pg_pkg;

    localparam int SLOT_W  = 5;
    localparam int PHASE_B = 20;
    localparam int FREQ_B  = 17;

    typedef logic [SLOT_W-1:0]  slot_t;
    typedef logic [PHASE_B-1:0] phase_t;
    typedef logic [FREQ_B-1:0]  freq_t;

    localparam logic [4:0] DT_TABLE [0:2][0:31] = '{
        '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2,
          5'd2, 5'd3, 5'd3, 5'd3, 5'd4, 5'd4, 5'd4, 5'd5, 5'd5, 5'd6, 5'd6, 5'd7, 5'd8, 5'd8, 5'd8, 5'd8},
        '{5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd3, 5'd3, 5'd3, 5'd4, 5'd4, 5'd4, 5'd5,
          5'd5, 5'd6, 5'd6, 5'd7, 5'd8, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd16, 5'd16, 5'd16, 5'd16},
        '{5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd3, 5'd3, 5'd3, 5'd4, 5'd4, 5'd4, 5'd5, 5'd5, 5'd6, 5'd6, 5'd7,
          5'd8, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd16, 5'd17, 5'd19, 5'd20, 5'd22, 5'd22, 5'd22, 5'd22}
    };

    // Keycode: octave, top fnum bit, and a note bit rounding the upper fnum nibble.
    function automatic logic [4:0] keycode(input logic [2:0] block, input logic [3:0] f);
        logic note;
        note = (f[3] & (f[2] | f[1] | f[0])) | (~f[3] & f[2] & f[1] & f[0]);
        return {block, f[3], note};
    endfunction

endpackage

// File: rtl/ym3438_pg_inc.sv
// Combinational increment datapath: block shift + detune (stage 1) and
// multiple (stage 2). The stage registers live in the parent.
module ym3438_pg_inc
    import ym3438_pg_pkg::*;
(
    input  logic [11:0] fnum_lfo,
    input  logic [2:0]  block,
    input  logic [2:0]  dt,
    input  freq_t       freq_q,
    input  logic [3:0]  mul_q,
    output freq_t       freq_d,
    output phase_t      inc_d
);

    logic [18:0] shifted;
    logic [4:0]  kc;
    logic [4:0]  det;
    logic [1:0]  dt_row;
    logic [20:0] product;

    always_comb begin
        shifted = {7'd0, fnum_lfo} << block;
        kc      = keycode(block, fnum_lfo[11:8]);
        dt_row  = dt[1:0] - 2'd1;
        det     = (dt[1:0] == 2'd0) ? 5'd0 : DT_TABLE[dt_row][kc];
        // Detune wraps modulo 2^17 in both directions.
        freq_d  = dt[2] ? (shifted[18:2] - freq_t'(det)) : (shifted[18:2] + freq_t'(det));

        product = {4'd0, freq_q} * {17'd0, mul_q};
        inc_d   = (mul_q == 4'd0) ? {4'd0, freq_q[16:1]} : product[19:0];
    end

endmodule

// File: rtl/ym3438_pg.sv
// YM3438 phase generator: 3-step pipeline accumulating one 20-bit phase per
// slot in a slot-addressed memory, emitting the top 10 bits with their slot tag.
module ym3438_pg
    import ym3438_pg_pkg::*;
#(
    parameter int SLOTS   = 24,
    parameter int PHASE_W = 20
) (
    input  logic        MCLK,
    input  logic        IC,
    input  logic        slot_en,
    input  logic        sync,
    input  logic [11:0] fnum_lfo,
    input  logic [2:0]  block,
    input  logic [2:0]  dt,
    input  logic [3:0]  mul,
    input  logic        pg_reset,
    output logic [9:0]  phase_out,
    output logic [4:0]  phase_slot,
    output logic        phase_valid
);

    slot_t        slot_cnt_reg;
    slot_t        slot_cnt_next;
    freq_t        freq_reg;
    logic [3:0]   mul_reg;
    slot_t        tag1_reg;
    logic         rst1_reg;
    phase_t       inc_reg;
    slot_t        tag2_reg;
    logic         rst2_reg;
    logic [1:0]   fill_reg;
    freq_t        freq_next;
    phase_t       inc_next;
    logic [PHASE_W-1:0] phase_next;
    logic [PHASE_W-1:0] phase_mem [SLOTS];

    ym3438_pg_inc u_inc (
        .fnum_lfo (fnum_lfo),
        .block    (block),
        .dt       (dt),
        .freq_q   (freq_reg),
        .mul_q    (mul_reg),
        .freq_d   (freq_next),
        .inc_d    (inc_next)
    );

    always_comb begin
        slot_cnt_next = slot_cnt_reg + slot_t'(1);
        if (sync || slot_cnt_reg == slot_t'(SLOTS - 1)) begin
            slot_cnt_next = '0;
        end
        // Key-on reset wins over accumulation.
        phase_next = rst2_reg ? '0 : (phase_mem[tag2_reg] + PHASE_W'(inc_reg));
    end

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            slot_cnt_reg <= '0;
            freq_reg     <= '0;
            mul_reg      <= '0;
            tag1_reg     <= '0;
            rst1_reg     <= 1'b0;
            inc_reg      <= '0;
            tag2_reg     <= '0;
            rst2_reg     <= 1'b0;
            fill_reg     <= '0;
            phase_out    <= '0;
            phase_slot   <= '0;
            phase_valid  <= 1'b0;
        end else if (slot_en) begin
            slot_cnt_reg <= slot_cnt_next;
            freq_reg     <= freq_next;
            mul_reg      <= mul;
            tag1_reg     <= slot_cnt_reg;
            rst1_reg     <= pg_reset;
            inc_reg      <= inc_next;
            tag2_reg     <= tag1_reg;
            rst2_reg     <= rst1_reg;
            phase_out    <= phase_next[PHASE_W-1:PHASE_W-10];
            phase_slot   <= tag2_reg;
            // Valid once the first real sample has reached the output stage.
            if (fill_reg != 2'd2) begin
                fill_reg <= fill_reg + 2'd1;
            end else begin
                phase_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            for (int i = 0; i < SLOTS; i++) begin
                phase_mem[i] <= '0;
            end
        end else if (slot_en) begin
            phase_mem[tag2_reg] <= phase_next;
        end
    end

endmodule

// File: tb/tb_ym3438_pg.sv
// Directed bench for ym3438_pg: an arithmetic per-slot phase model checked
// every cycle, plus hand-computed literal expectations.
module tb_ym3438_pg;

    logic        MCLK = 1'b0;
    logic        IC;
    logic        slot_en;
    logic        sync;
    logic [11:0] fnum_lfo;
    logic [2:0]  block;
    logic [2:0]  dt;
    logic [3:0]  mul;
    logic        pg_reset;
    logic [9:0]  phase_out;
    logic [4:0]  phase_slot;
    logic        phase_valid;

    int vectors     = 0;
    int miscompares = 0;

    always #5 MCLK = ~MCLK;

    ym3438_pg dut (
        .MCLK        (MCLK),
        .IC          (IC),
        .slot_en     (slot_en),
        .sync        (sync),
        .fnum_lfo    (fnum_lfo),
        .block       (block),
        .dt          (dt),
        .mul         (mul),
        .pg_reset    (pg_reset),
        .phase_out   (phase_out),
        .phase_slot  (phase_slot),
        .phase_valid (phase_valid)
    );

    int dt_tab [96] = '{
        0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2,
        2, 3, 3, 3, 4, 4, 4, 5, 5, 6, 6, 7, 8, 8, 8, 8,
        1, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 3, 4, 4, 4, 5,
        5, 6, 6, 7, 8, 8, 9, 10, 11, 12, 13, 14, 16, 16, 16, 16,
        2, 2, 2, 2, 2, 3, 3, 3, 4, 4, 4, 5, 5, 6, 6, 7,
        8, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 20, 22, 22, 22, 22
    };

    typedef struct {
        int slot;
        int out;
    } exp_t;

    exp_t pipe [$];
    int   m_phase [24];
    int   obs [24];
    int   m_slot    = 0;
    int   exp_out   = 0;
    int   exp_slot  = 0;
    int   exp_valid = 0;

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_clear();
        pipe.delete();
        for (int i = 0; i < 24; i++) begin
            m_phase[i] = 0;
            obs[i]     = -1;
        end
        m_slot    = 0;
        exp_out   = 0;
        exp_slot  = 0;
        exp_valid = 0;
    endtask

    // Phase produced by one slot visit, from the frequency rules directly.
    task automatic model_step(input int sy, input int fn, input int bl, input int d,
                              input int m, input int pr);
        int   f, kc, det, freq, inc, nxt;
        exp_t e;
        f    = fn / 256;
        kc   = bl * 4 + ((f >= 8) ? 2 : 0) + (((f >= 8) ? (f > 8) : (f == 7)) ? 1 : 0);
        det  = ((d % 4) == 0) ? 0 : dt_tab[((d % 4) - 1) * 32 + kc];
        freq = (fn * (1 << bl)) / 4;
        freq = ((d >= 4) ? (freq - det) : (freq + det)) & 'h1FFFF;
        inc  = (m == 0) ? (freq / 2) : ((freq * m) & 'hFFFFF);
        nxt  = (pr != 0) ? 0 : ((m_phase[m_slot] + inc) & 'hFFFFF);
        m_phase[m_slot] = nxt;
        e.slot = m_slot;
        e.out  = nxt / 1024;
        pipe.push_back(e);
        if (pipe.size() == 3) begin
            e         = pipe.pop_front();
            exp_out   = e.out;
            exp_slot  = e.slot;
            exp_valid = 1;
        end
        m_slot = ((sy != 0) || (m_slot == 23)) ? 0 : m_slot + 1;
    endtask

    task automatic compare();
        chk("phase_valid", int'(phase_valid), exp_valid);
        if (exp_valid != 0) begin
            chk("phase_slot", int'(phase_slot), exp_slot);
            chk("phase_out", int'(phase_out), exp_out);
        end
        if (phase_valid && phase_slot < 5'd24) begin
            obs[phase_slot] = int'(phase_out);
        end
    endtask

    // Drive at a negedge, step on the posedge, check on the next negedge.
    task automatic step(input int en, input int sy, input int fn, input int bl,
                        input int d, input int m, input int pr);
        slot_en  = (en != 0);
        sync     = (sy != 0);
        fnum_lfo = 12'(fn);
        block    = 3'(bl);
        dt       = 3'(d);
        mul      = 4'(m);
        pg_reset = (pr != 0);
        @(posedge MCLK);
        if (en != 0) begin
            model_step(sy, fn, bl, d, m, pr);
        end
        @(negedge MCLK);
        compare();
    endtask

    // Periodic sync on slot 23; pg_reset raised on slot rs.
    task automatic run_steps(input int n, input int fn, input int bl, input int d,
                             input int m, input int rs);
        for (int i = 0; i < n; i++) begin
            step(1, (m_slot == 23) ? 1 : 0, fn, bl, d, m, (m_slot == rs) ? 1 : 0);
        end
    endtask

    // IC dropped between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        slot_en = 1'b0;
        @(posedge MCLK);
        #2;
        IC = 1'b0;
        model_clear();
        #1;
        chk("async phase_out", int'(phase_out), 0);
        chk("async phase_slot", int'(phase_slot), 0);
        chk("async phase_valid", int'(phase_valid), 0);
        @(negedge MCLK);
        compare();
        @(negedge MCLK);
        IC = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        IC = 1'b0;
        slot_en = 1'b0; sync = 1'b0; fnum_lfo = '0; block = '0; dt = '0; mul = '0; pg_reset = 1'b0;
        model_clear();
        @(negedge MCLK);
        chk("reset phase_out", int'(phase_out), 0);
        chk("reset phase_slot", int'(phase_slot), 0);
        chk("reset phase_valid", int'(phase_valid), 0);
        compare();
        @(negedge MCLK);
        IC = 1'b1;

        // Basic increment 0x1000 per pass, wraps after 256 passes.
        run_steps(24, 'h400, 4, 0, 1, -1);
        chk("t1 slot0 pass1", obs[0], 'h004);
        run_steps(255 * 24, 'h400, 4, 0, 1, -1);
        chk("t1 slot0 pass256", obs[0], 'h000);
        chk("t1 slot10 pass256", obs[10], 'h000);

        // Multiple 0 and 15.
        do_reset();
        run_steps(24, 'h400, 4, 0, 0, -1);
        chk("t2 mul0", obs[0], 'h002);
        do_reset();
        run_steps(24, 'h400, 4, 0, 15, -1);
        chk("t2 mul15", obs[0], 'h03C);

        // Detune: +2, -2 (visible after 256 passes), wrap below zero, kc=31 rows.
        do_reset();
        run_steps(24, 'h400, 4, 1, 1, -1);
        chk("t3 dt1 pass1", obs[0], 'h004);
        do_reset();
        run_steps(256 * 24, 'h400, 4, 5, 1, -1);
        chk("t3 dt5 pass256", obs[0], 'h3FF);
        do_reset();
        run_steps(24, 'h000, 4, 5, 1, -1);
        chk("t3 dt5 wrap", obs[0], 'h07F);
        run_steps(24, 'hFFF, 7, 2, 3, -1);
        run_steps(24, 'hFFF, 7, 7, 1, -1);
        run_steps(24, 'h9A5, 2, 3, 9, -1);

        // Key-on reset of slot 7 after it reached 0x00A.
        do_reset();
        run_steps(5 * 24, 'h400, 4, 0, 0, -1);
        chk("t4 slot7 before", obs[7], 'h00A);
        run_steps(24, 'h400, 4, 0, 0, 7);
        chk("t4 slot7 reset", obs[7], 'h000);
        chk("t4 slot6 kept", obs[6], 'h00C);
        chk("t4 slot8 kept", obs[8], 'h00C);
        run_steps(24, 'h400, 4, 0, 0, -1);
        chk("t4 slot7 resume", obs[7], 'h002);

        // Stall with noisy inputs, then sync at counter 11.
        run_steps(6, 'h400, 4, 0, 0, -1);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 'hABC, 7, 6, 9, 1);
            chk("t5 stall slot", int'(phase_slot), 3);
            chk("t5 stall out", int'(phase_out), 'h010);
        end
        run_steps(5, 'h400, 4, 0, 0, -1);
        step(1, 1, 'h400, 4, 0, 0, 0);
        run_steps(3, 'h400, 4, 0, 0, -1);
        chk("t5 sync slot", int'(phase_slot), 0);
        chk("t5 sync out", int'(phase_out), 'h012);
        run_steps(21, 'h400, 4, 0, 0, -1);
        chk("t5 slot12 continues", obs[12], 'h010);
        chk("t5 slot11 continues", obs[11], 'h012);

        // Mid-cycle async reset: pipeline refills from zero.
        run_steps(5, 'h400, 4, 0, 0, -1);
        do_reset();
        run_steps(2, 'h400, 4, 0, 0, -1);
        chk("t6 valid low", int'(phase_valid), 0);
        run_steps(1, 'h400, 4, 0, 0, -1);
        chk("t6 valid high", int'(phase_valid), 1);
        chk("t6 first slot", int'(phase_slot), 0);
        chk("t6 first out", int'(phase_out), 'h002);
        run_steps(21, 'h400, 4, 0, 0, -1);
        chk("t6 slot4 restart", obs[4], 'h002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ym3438_pg.md
# ym3438_pg

Per-slot phase generator for the YM3438 operator pipeline, directly downstream of the LFO stage. It consumes the LFO-modulated 12-bit frequency number `fnum_lfo` together with each slot's block, detune and multiple settings, and forms the 20-bit phase increment. It accumulates one 20-bit phase per slot across the 24-slot time-multiplexed cycle and hands the top 10 phase bits to the operator (sine lookup) stage.

## Interface

Parameters:
- `SLOTS`, 24: slots per cycle; sets phase memory depth and slot-counter wrap.
- `PHASE_W`, 20: accumulator width.

Ports:
- `MCLK`  in  1  system clock, the only clock.
- `IC`  in  1  reset, asynchronous, active-low.
- `slot_en`  in  1  slot-step strobe. All state advances only on `MCLK` rising edges with `slot_en`=1.
- `sync`  in  1  cycle alignment. With `slot_en`, the next slot index is 0.
- `fnum_lfo`  in  12  modulated frequency number for the current slot (fnum·2 + PM).
- `block`  in  3  octave.
- `dt`  in  3  detune: bit 2 is the sign, bits 1:0 the magnitude.
- `mul`  in  4  frequency multiple.
- `pg_reset`  in  1  key-on phase reset for the current slot.
- `phase_out`  out  10  phase[19:10] of the slot leaving the accumulator.
- `phase_slot`  out  5  slot index belonging to `phase_out`.
- `phase_valid`  out  1  high once the pipeline holds real data.

## Operation

- **Slot counter** (5 bits) tags the inputs sampled on each step.
  - Sequence 0..23, then wraps to 0.
  - `sync` forces 0 on the next step. Asserting `sync` while the counter is at 23 has no extra effect.
- **Stage 1, block shift**:
  - freq = (`fnum_lfo` << `block`) >> 2, giving 17 bits.
- **Stage 1, keycode**:
  - Let f = `fnum_lfo[11:8]`.
  - kc = {`block`, f[3], note}, where note = (f[3] & (f[2]|f[1]|f[0])) | (~f[3] & f[2] & f[1] & f[0]).
- **Stage 1, detune**:
  - d = DT_TABLE[`dt[1:0]`][kc]; `dt[1:0]`=0 gives d = 0.
  - freq ± d (minus when `dt[2]`=1), wrapping modulo 2^17.
  - The 17-bit result is registered.
- **Stage 2, multiple**:
  - `mul`=0: inc = freq >> 1.
  - Otherwise inc = freq·`mul`, truncated to 20 bits.
  - The result is registered.
- **Stage 3, accumulate**:
  - Phase memory is 24×20 bits, addressed by the slot tag carried through the pipeline. It is not a rotating shift register, so `sync` realignment cannot corrupt stored phases.
  - Next value = mem[slot] + inc, mod 2^20.
  - If `pg_reset` (carried with the slot tag) is set, the next value is 0. `pg_reset` overrides accumulation.
  - `phase_out` = next[19:10] and `phase_slot` = slot, both registered.
- **Reset**: while `IC`=0, all of the following clear to 0:
  - the phase memory;
  - the slot counter;
  - the pipeline registers (freq, inc, tags, pg_reset flags);
  - `phase_out`, `phase_slot` and `phase_valid`.
  
  A reset mid-cycle discards all in-flight slots.

## Timing

- Latency is 3 `slot_en` steps. Inputs sampled on step n with tag k appear on `phase_out`/`phase_slot`=k after step n+2.
- `phase_valid` rises after the third step following reset release and stays high until the next reset.
- Steps with `slot_en`=0 hold every register and memory word unchanged.
- Each phase advances once per 24 steps when `sync` is periodic.
- A read-modify-write to the same slot on consecutive steps cannot occur, because tags differ by 1.

## Structure

- Package `ym3438_pg_pkg` holds:
  - `DT_TABLE`: 3×32 entries of 5-bit detune values, the standard OPN2 detune table. Selected entries for the bench: [dt=1][kc=16]=2, [dt=2][kc=31]=16, [dt=3][kc=31]=22.
  - `slot_t` (5 bits), `phase_t` (20 bits), `freq_t` (17 bits).
- Sub-module `ym3438_pg_inc`: combinational `fnum_lfo`/`block`/`dt`/`mul` → 20-bit inc, with registers in the parent. It is reused by the test-register readback path.

## Test plan

1. **Basic increment**: `fnum_lfo`=0x400, `block`=4, `dt`=0, `mul`=1 on all slots with periodic `sync`.
   - inc=0x1000; slot 0 `phase_out` after the first pass = 0x004.
   - After 256 passes it wraps to 0x000.
2. **Multiple**: same frequency setup, inc = 0x0800 for `mul`=0 and 0xF000 for `mul`=15. Check `phase_out` after one pass = 0x002 and 0x03C respectively.
3. **Detune**: `fnum_lfo`=0x400, `block`=4 (kc=16).
   - `dt`=1 gives freq 0x1002.
   - `dt`=5 gives freq 0x0FFE.
   - With `fnum_lfo`=0 and `dt`=5, freq wraps to 0x1FFFE.
4. **Key-on reset**: slot 7 has accumulated to 0x00A.
   - Pulse `pg_reset` with slot 7 → that pass's `phase_out` = 0x000.
   - Slots 6 and 8 are unaffected.
5. **Stall and sync**:
   - Hold `slot_en`=0 for 10 cycles → outputs are frozen.
   - Assert `sync` at counter=11 → the next tag is 0 and each slot's phase continues from its stored value.
6. **Async reset**: drop `IC` between edges mid-cycle.
   - Outputs go to 0 immediately.
   - After release, `phase_valid`=0 for 3 steps and all phases restart from 0.
